// File: rtl/ct_f_spsram_ctrl_pkg.sv
// ============================================================================
//  Module      : ct_f_spsram_ctrl_pkg
//  Description : Shared types and default geometry for the 4096x84
//                single-port SRAM access controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ct_f_spsram_ctrl_pkg;

    // Default array geometry: 4096 words of 84 bits
    localparam int c_DEF_ADDR_WIDTH = 12;
    localparam int c_DEF_DATA_WIDTH = 84;

    // Controller states; INIT only exists when the init sweep is built in
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RDOUT = 2'd2
    } ctrl_state_t;

endpackage : ct_f_spsram_ctrl_pkg

`default_nettype wire

// File: rtl/ct_f_spsram_ctrl_4096x84.sv
// ============================================================================
//  Module      : ct_f_spsram_ctrl_4096x84
//  Description : Access controller in front of the 4096x84 single-port SRAM
//                wrapper. Turns a valid/ready request stream into the SRAM's
//                active-low CEN/GWEN/WEN protocol and returns read data on a
//                valid/ready response port. Read backpressure is absorbed by
//                holding CEN high so the SRAM keeps Q stable.
//                Optional post-reset clear sweep: CT_F_SPSRAM_CTRL_INIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_f_spsram_ctrl_4096x84
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    // client request port
    input  logic                  req_vld,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    // read response port
    output logic                  rd_vld,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    // status
    output logic                  init_done,
    // SRAM pins
    output logic [ADDR_WIDTH-1:0] sram_A,
    output logic                  sram_CEN,
    output logic                  sram_GWEN,
    output logic [DATA_WIDTH-1:0] sram_WEN,
    output logic [DATA_WIDTH-1:0] sram_D,
    input  logic [DATA_WIDTH-1:0] sram_Q
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic        w_accept;

`ifdef CT_F_SPSRAM_CTRL_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;
    localparam ctrl_state_t           c_RST_STATE = ST_INIT;

    logic [ADDR_WIDTH-1:0] r_init_cnt;

    // Sweep address counter: restarts on reset, advances every INIT cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_init_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    assign init_done = (r_state != ST_INIT);
`else
    localparam ctrl_state_t c_RST_STATE = ST_IDLE;

    // Without the sweep the clear value has no consumer
    logic w_unused_init;
    assign w_unused_init = ^INIT_VALUE;

    assign init_done = 1'b1;
`endif

    // A request can be taken when idle, or when the pending read is consumed
    assign req_ready = (r_state == ST_IDLE) | ((r_state == ST_RDOUT) & rd_ready);
    assign w_accept  = req_vld & req_ready;
    assign rd_vld    = (r_state == ST_RDOUT);
    // SRAM holds Q while CEN is high, so no local data buffer is required
    assign rd_data   = sram_Q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and SRAM pin decode
    always_comb begin
        w_state_nxt = r_state;
        sram_CEN    = 1'b1;
        sram_GWEN   = 1'b1;
        sram_WEN    = '1;
        sram_A      = req_addr;
        sram_D      = req_wdata;

        case (r_state)
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
            ST_INIT: begin
                sram_CEN  = 1'b0;
                sram_GWEN = 1'b0;
                sram_WEN  = '0;
                sram_A    = r_init_cnt;
                sram_D    = INIT_VALUE;
                if (r_init_cnt == c_LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            ST_IDLE, ST_RDOUT: begin
                if (w_accept) begin
                    if (req_wr) begin
                        // An all-zero mask is accepted but touches nothing
                        if (|req_wmask) begin
                            sram_CEN  = 1'b0;
                            sram_GWEN = 1'b0;
                            sram_WEN  = ~req_wmask;
                        end
                        w_state_nxt = ST_IDLE;
                    end else begin
                        sram_CEN    = 1'b0;
                        w_state_nxt = ST_RDOUT;
                    end
                end else if ((r_state == ST_RDOUT) && rd_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_RST_STATE;
            end
        endcase
    end

endmodule : ct_f_spsram_ctrl_4096x84

`default_nettype wire

// File: tb/tb_ct_f_spsram_ctrl_4096x84.sv
// ============================================================================
//  Module      : tb_ct_f_spsram_ctrl_4096x84
//  Description : Directed self-checking bench for ct_f_spsram_ctrl_4096x84
//                with a behavioural single-port SRAM model on the pins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ct_f_spsram_ctrl_4096x84;

    localparam int AW = 12;
    localparam int DW = 84;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req_vld;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rd_vld;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          init_done;
    logic [AW-1:0] sram_A;
    logic          sram_CEN;
    logic          sram_GWEN;
    logic [DW-1:0] sram_WEN;
    logic [DW-1:0] sram_D;
    logic [DW-1:0] sram_Q;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [DW-1:0] c_PAT_A5  = 84'hA5A5A5A5A5A5A5A5A5A5A;
    localparam logic [DW-1:0] c_ONES    = '1;
    localparam logic [DW-1:0] c_LOW8    = 84'hFF;
    localparam logic [DW-1:0] c_PART    = 84'hFFFFFFFFFFFFFFFFFFF00;

    always #5 CLK = ~CLK;

    ct_f_spsram_ctrl_4096x84 dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_vld   (req_vld),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rd_vld    (rd_vld),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .init_done (init_done),
        .sram_A    (sram_A),
        .sram_CEN  (sram_CEN),
        .sram_GWEN (sram_GWEN),
        .sram_WEN  (sram_WEN),
        .sram_D    (sram_D),
        .sram_Q    (sram_Q)
    );

    // Behavioural single-port SRAM: per-bit active-low write, Q held when idle
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (!sram_CEN) begin
            if (!sram_GWEN) begin
                mem[sram_A] <= (mem[sram_A] & sram_WEN) | (sram_D & ~sram_WEN);
            end else begin
                sram_Q <= mem[sram_A];
            end
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
        #1;
        chk("wr_ready", req_ready, 1'b1);
        chk("wr_cen", sram_CEN, (m == '0) ? 1'b1 : 1'b0);
        tick();
        req_vld = 1'b0; req_wr = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = a;
        #1;
        chk("rd_req_ready", req_ready, 1'b1);
        tick();
        req_vld = 1'b0;
        #1;
        chk("rd_vld", rd_vld, 1'b1);
        chk("rd_data", rd_data, exp);
        tick();
    endtask

    initial begin
        logic [DW-1:0] held;
        int            sweep_bad;
        int            waited;

        RST = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rd_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_rd_vld", rd_vld, 1'b0);
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        RST = 1'b0;
        // Sweep: cycle n (1-based) writes address n-1
        sweep_bad = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            #1;
            if (sram_CEN !== 1'b0 || sram_GWEN !== 1'b0 || sram_A !== AW'(i) ||
                sram_D !== '0 || sram_WEN !== '0 || init_done !== 1'b0 || req_ready !== 1'b0)
                sweep_bad++;
            tick();
        end
        chk("sweep_cycles_bad", DW'(sweep_bad), '0);
        #1;
        chk("init_done_4097", init_done, 1'b1);
        chk("ready_after_init", req_ready, 1'b1);
        do_read(12'hFFF, '0);
`else
        RST = 1'b0;
        #1;
        chk("noinit_ready", req_ready, 1'b1);
        chk("noinit_done", init_done, 1'b1);
`endif

        // Full-mask write then read
        do_write(12'h123, c_PAT_A5, c_ONES);
        do_read(12'h123, c_PAT_A5);

        // Partial mask, and a zero mask that must change nothing
        do_write(12'h010, c_ONES, c_ONES);
        do_write(12'h010, '0, c_LOW8);
        do_write(12'h010, '0, '0);
        do_read(12'h010, c_PART);

        // Backpressure: response held, no new request taken
        rd_ready = 1'b0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 12'h123;
        tick();
        req_addr = 12'h010;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k == 0) held = rd_data;
            chk("bp_cen", sram_CEN, 1'b1);
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_rd_vld", rd_vld, 1'b1);
            chk("bp_rd_data", rd_data, c_PAT_A5);
            chk("bp_stable", rd_data, held);
            tick();
        end
        req_vld = 1'b0;
        rd_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 1'b1);
        tick();
        chk("bp_back_idle", rd_vld, 1'b0);

        // Back-to-back reads at full throughput
        do_write(12'h001, 84'h1, c_ONES);
        do_write(12'h002, 84'h2, c_ONES);
        do_write(12'h003, 84'h3, c_ONES);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 12'h001;
        #1; chk("b2b_ready0", req_ready, 1'b1);
        tick();
        req_addr = 12'h002;
        #1; chk("b2b_ready1", req_ready, 1'b1);
        chk("b2b_vld1", rd_vld, 1'b1); chk("b2b_data1", rd_data, 84'h1);
        tick();
        req_addr = 12'h003;
        #1; chk("b2b_ready2", req_ready, 1'b1);
        chk("b2b_vld2", rd_vld, 1'b1); chk("b2b_data2", rd_data, 84'h2);
        tick();
        // Write accepted in the same cycle the last read is consumed
        req_wr = 1'b1; req_addr = 12'h005; req_wdata = 84'h5A; req_wmask = c_ONES;
        #1; chk("b2b_vld3", rd_vld, 1'b1); chk("b2b_data3", rd_data, 84'h3);
        chk("rdout_wr_gwen", sram_GWEN, 1'b0);
        tick();
        req_vld = 1'b0; req_wr = 1'b0;
        #1; chk("rdout_wr_to_idle", rd_vld, 1'b0);
        do_read(12'h005, 84'h5A);

        // Reset while a read is pending
        rd_ready = 1'b0;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 12'h123;
        tick();
        req_vld = 1'b0;
        chk("pre_rst_rd_vld", rd_vld, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        rd_ready = 1'b1;
        #1;
        chk("midrst_rd_vld", rd_vld, 1'b0);
`ifdef CT_F_SPSRAM_CTRL_INIT_EN
        chk("midrst_req_ready", req_ready, 1'b0);
        chk("midrst_addr0", sram_A, '0);
        chk("midrst_cen", sram_CEN, 1'b0);
        waited = 0;
        while (init_done !== 1'b1 && waited < 5000) begin
            tick();
            waited++;
        end
        chk("midrst_sweep_len", DW'(waited), DW'(1 << AW));
        do_read(12'h123, '0);
`else
        chk("midrst_req_ready", req_ready, 1'b1);
        chk("midrst_init_done", init_done, 1'b1);
        do_read(12'h123, c_PAT_A5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ct_f_spsram_ctrl_4096x84

`default_nettype wire
